// File: rtl/nios_dbg_pkg.sv
// Shared field positions, command record and helpers for the debug-slave
// system-clock command engine.
package nios_dbg_pkg;

  localparam int SUB_W    = 2;
  localparam int DEF_IR_W = 2;
  localparam int DEF_SR_W = 38;

  localparam int ACTION_BIT = DEF_SR_W - 1;
  localparam int SUB_HI     = DEF_SR_W - 2;
  localparam int SUB_LO     = DEF_SR_W - 3;

  // Same positions for an arbitrary shift-register width.
  function automatic int action_bit(input int sr_w);
    return sr_w - 1;
  endfunction

  function automatic int sub_hi(input int sr_w);
    return sr_w - 2;
  endfunction

  function automatic int sub_lo(input int sr_w);
    return sr_w - 3;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [DEF_IR_W-1:0] ch;
    logic                action;
    logic [SUB_W-1:0]    sub;
    logic [DEF_SR_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/nios_dbg_cmd_fifo.sv
// First-word-fall-through command FIFO with occupancy count and drop-on-full.
module nios_dbg_cmd_fifo
  import nios_dbg_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [W-1:0]         wdata_i,
  output logic                 drop_o,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [W-1:0]         rdata_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = ready_i & ~empty;
  // A pop frees the slot in the same cycle, so full+push+pop still accepts.
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & full & ~do_pop;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; count_q gates visibility, so stale words are never presented.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign valid_o = ~empty;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/nios_dbg_cmd_sysclk.sv
// System-clock side of the CPU JTAG debug slave: synchronises update strobes,
// decodes per-instruction action pulses and queues each command.
module nios_dbg_cmd_sysclk
  import nios_dbg_pkg::*;
#(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int SYNC_STAGES = 2,
  parameter int CMD_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vs_uir,
  input  logic                      vs_udr,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [SR_W-1:0]           sr,
  output logic [SR_W-1:0]           jdo,
  output logic [(1<<IR_W)-1:0]      take_action,
  output logic [(1<<IR_W)-1:0]      take_no_action,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [IR_W-1:0]           cmd_ch,
  output logic                      cmd_action,
  output logic [1:0]                cmd_sub,
  output logic [SR_W-1:0]           cmd_data,
  output logic [clog2(CMD_DEPTH):0] fifo_count,
  output logic                      overflow,
  input  logic                      clr_overflow
);

  localparam int NUM_CH = 1 << IR_W;
  localparam int CMD_W  = IR_W + 1 + SUB_W + SR_W;
  localparam int A_BIT  = action_bit(SR_W);
  localparam int S_HI   = sub_hi(SR_W);
  localparam int S_LO   = sub_lo(SR_W);

  logic [SYNC_STAGES-1:0] fill_q;
  logic [1:0]             strobe, evt;
  logic                   udr_evt, uir_evt;
  logic [IR_W-1:0]        ir_q, ir_eff;
  logic [NUM_CH-1:0]      ir_onehot, take_action_q, take_no_action_q;
  logic [SR_W-1:0]        jdo_q;
  logic                   push_q, drop, overflow_q;
  logic [CMD_W-1:0]       push_data, head;

  assign strobe = {vs_uir, vs_udr};

  // fill_q marks when every synchroniser stage holds a real sample, not reset zeros.
  always_ff @(posedge clk) begin
    if (reset) fill_q <= '0;
    else       fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
  end

  for (genvar g = 0; g < 2; g++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q, arm_q, evt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '0;
        prev_q <= 1'b0;
        arm_q  <= 1'b0;
        evt_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], strobe[g]};
        prev_q <= sync_q[SYNC_STAGES-1];
        arm_q  <= arm_q | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
        evt_q  <= arm_q & sync_q[SYNC_STAGES-1] & ~prev_q;
      end
    end

    assign evt[g] = evt_q;
  end

  assign udr_evt = evt[0];
  assign uir_evt = evt[1];

  // A coincident IR update wins, so the command sees the new instruction.
  assign ir_eff    = uir_evt ? ir_in : ir_q;
  assign ir_onehot = NUM_CH'(1) << ir_eff;

  // NOTE: all state updates use <=; the push below reads ir_q/jdo_q as they were before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q             <= '0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      push_q           <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      if (uir_evt) ir_q  <= ir_in;
      if (udr_evt) jdo_q <= sr;
      take_action_q    <= (udr_evt &  sr[A_BIT]) ? ir_onehot : '0;
      take_no_action_q <= (udr_evt & ~sr[A_BIT]) ? ir_onehot : '0;
      push_q           <= udr_evt;
      if (drop)              overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  assign push_data = {ir_q, jdo_q[A_BIT], jdo_q[S_HI:S_LO], jdo_q};

  nios_dbg_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_q),
    .wdata_i (push_data),
    .drop_o  (drop),
    .ready_i (cmd_ready),
    .valid_o (cmd_valid),
    .rdata_o (head),
    .count_o (fifo_count)
  );

  assign {cmd_ch, cmd_action, cmd_sub, cmd_data} = head;
  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_nios_dbg_cmd_sysclk.sv
// Scoreboard bench for nios_dbg_cmd_sysclk: stimulus queues expected pulses and
// commands, independent monitors pop and compare them as the DUT presents them.
`timescale 1ns/1ps
module tb_nios_dbg_cmd_sysclk;
  import nios_dbg_pkg::*;

  localparam int IR_W = 2;
  localparam int SR_W = 38;

  logic            clk = 1'b0, reset = 1'b1;
  logic            vs_uir = 1'b0, vs_udr = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            cmd_ready = 1'b0, clr_overflow = 1'b0;
  logic [SR_W-1:0] jdo, cmd_data;
  logic [3:0]      take_action, take_no_action;
  logic            cmd_valid, cmd_action, overflow;
  logic [IR_W-1:0] cmd_ch;
  logic [1:0]      cmd_sub;
  logic [2:0]      fifo_count;

  nios_dbg_cmd_sysclk dut (
    .clk            (clk),
    .reset          (reset),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ch         (cmd_ch),
    .cmd_action     (cmd_action),
    .cmd_sub        (cmd_sub),
    .cmd_data       (cmd_data),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0]      ta;
    logic [3:0]      tna;
    logic [SR_W-1:0] jdo;
    int              cyc;
  } pulse_t;

  pulse_t exp_pulse_q[$];
  cmd_t   exp_cmd_q[$];
  pulse_t mon_p;
  cmd_t   mon_c;

  // Pulse monitor: any nonzero pulse must match the oldest expected one.
  always @(negedge clk) begin
    if (take_action != 4'b0 || take_no_action != 4'b0) begin
      if (exp_pulse_q.size() == 0) begin
        check("unexpected_pulse", {take_action, take_no_action}, 64'h0);
      end else begin
        mon_p = exp_pulse_q.pop_front();
        check("take_action", take_action, mon_p.ta);
        check("take_no_action", take_no_action, mon_p.tna);
        check("jdo", jdo, mon_p.jdo);
        check("pulse_cycle", cyc, mon_p.cyc);
      end
    end
  end

  // Command monitor: each accepted head must match the oldest expected command.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      if (exp_cmd_q.size() == 0) begin
        check("unexpected_cmd", cmd_valid, 64'h0);
      end else begin
        mon_c = exp_cmd_q.pop_front();
        check("cmd_ch", cmd_ch, mon_c.ch);
        check("cmd_action", cmd_action, mon_c.action);
        check("cmd_sub", cmd_sub, mon_c.sub);
        check("cmd_data", cmd_data, mon_c.data);
      end
    end
  end

  logic valid_prev = 1'b0;
  int   valid_rise_cyc = -1;
  always @(negedge clk) begin
    if (cmd_valid && !valid_prev) valid_rise_cyc <= cyc;
    valid_prev <= cmd_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // All stimulus is applied 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [IR_W-1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    tick(4);
  endtask

  // One update-DR; the pulse is due 4 cycles after the strobe edge.
  task automatic udr_cmd(input logic [SR_W-1:0] v, input logic [IR_W-1:0] ch,
                         input bit push, input bit pop_with_push, output int start);
    pulse_t p;
    cmd_t   c;
    start  = cyc;
    sr     = v;
    vs_udr = 1'b1;
    p.ta   = v[37] ? (4'b0001 << ch) : 4'b0000;
    p.tna  = v[37] ? 4'b0000 : (4'b0001 << ch);
    p.jdo  = v;
    p.cyc  = start + 4;
    exp_pulse_q.push_back(p);
    if (push) begin
      c.ch     = ch;
      c.action = v[37];
      c.sub    = v[36:35];
      c.data   = v;
      exp_cmd_q.push_back(c);
    end
    tick(4);
    vs_udr = 1'b0;
    if (pop_with_push) begin
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
    end
    tick(4);
  endtask

  logic [SR_W-1:0] v3 [5];
  logic [SR_W-1:0] v4 [5];
  int st;

  initial begin
    v3[0] = 38'h3F_0000_0001;  // action 1, sub 11
    v3[1] = 38'h08_0000_0002;  // action 0, sub 01
    v3[2] = 38'h20_0000_0003;  // action 1, sub 00
    v3[3] = 38'h10_0000_0004;  // action 0, sub 10
    v3[4] = 38'h2A_AAAA_AAAA;  // dropped
    v4[0] = 38'h01_2345_6789;
    v4[1] = 38'h3E_DCBA_9876;
    v4[2] = 38'h15_5555_5555;
    v4[3] = 38'h28_0F0F_0F0F;
    v4[4] = 38'h33_C3C3_C3C3;

    // Reset state
    tick(3);
    check("rst_jdo", jdo, 64'h0);
    check("rst_take_action", take_action, 64'h0);
    check("rst_take_no_action", take_no_action, 64'h0);
    check("rst_cmd_valid", cmd_valid, 64'h0);
    check("rst_fifo_count", fifo_count, 64'h0);
    check("rst_overflow", overflow, 64'h0);
    reset = 1'b0;
    tick(6);

    // Action command on channel 2
    load_ir(2'd2);
    udr_cmd(38'h20_0000_1234, 2'd2, 1'b1, 1'b0, st);
    check("valid_rise_cycle", valid_rise_cyc, st + 5);
    check("head1_ch", cmd_ch, 64'd2);
    check("head1_action", cmd_action, 64'd1);
    check("head1_sub", cmd_sub, 64'd0);
    check("head1_data", cmd_data, 64'h20_0000_1234);
    check("jdo1", jdo, 64'h20_0000_1234);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("count_after_pop1", fifo_count, 64'd0);

    // No-action command on channel 1, sub-op 10
    load_ir(2'd1);
    udr_cmd(38'h10_0000_00AB, 2'd1, 1'b1, 1'b0, st);
    check("head2_ch", cmd_ch, 64'd1);
    check("head2_action", cmd_action, 64'd0);
    check("head2_sub", cmd_sub, 64'b10);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;

    // Overflow: five commands into a four-deep FIFO with no consumer
    for (int i = 0; i < 5; i++) udr_cmd(v3[i], 2'd1, i < 4, 1'b0, st);
    check("ovf_count", fifo_count, 64'd4);
    check("ovf_flag", overflow, 64'd1);
    cmd_ready = 1'b1;
    tick(6);
    cmd_ready = 1'b0;
    check("ovf_drained", fifo_count, 64'd0);
    check("ovf_sticky", overflow, 64'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 64'd0);

    // Full FIFO, push coincident with a pop
    for (int i = 0; i < 4; i++) udr_cmd(v4[i], 2'd1, 1'b1, 1'b0, st);
    udr_cmd(v4[4], 2'd1, 1'b1, 1'b1, st);
    check("full_pushpop_count", fifo_count, 64'd4);
    check("full_pushpop_ovf", overflow, 64'd0);
    cmd_ready = 1'b1;
    tick(6);
    cmd_ready = 1'b0;
    check("full_pushpop_drained", fifo_count, 64'd0);
    check("full_pushpop_all_seen", exp_cmd_q.size(), 64'd0);

    // Strobe already high at reset release
    vs_udr = 1'b1;
    reset  = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    check("held_high_count", fifo_count, 64'd0);
    check("held_high_valid", cmd_valid, 64'd0);
    vs_udr = 1'b0;
    tick(4);
    udr_cmd(38'h21_1111_1111, 2'd0, 1'b1, 1'b0, st);
    check("after_rearm_count", fifo_count, 64'd1);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;

    // Reset with three queued commands
    for (int i = 0; i < 3; i++) udr_cmd(v4[i], 2'd0, 1'b0, 1'b0, st);
    check("preflush_count", fifo_count, 64'd3);
    reset = 1'b1;
    tick(1);
    check("flush_valid", cmd_valid, 64'd0);
    check("flush_count", fifo_count, 64'd0);
    reset = 1'b0;
    tick(10);
    cmd_ready = 1'b1;
    tick(3);
    cmd_ready = 1'b0;
    check("pulses_all_seen", exp_pulse_q.size(), 64'd0);
    check("cmds_all_seen", exp_cmd_q.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_dbg_cmd_sysclk.md
Name: nios_dbg_cmd_sysclk

Overview:
- System-clock-side command engine for the CPU JTAG debug slave.
- Receives update-IR/update-DR strobes and the captured shift register from the TCK domain, and synchronises them.
- Decodes the strobes into per-instruction action pulses; the channel count is set by IR width, not fixed at 4.
- Also queues each command in a FIFO with a valid/ready handshake, so firmware or trace logic can consume commands at its own pace. Overflow is reported as a sticky flag.

Parameters:
- IR_W, 2, instruction register width; NUM_CH = 2**IR_W decode channels
- SR_W, 38, data shift register width (>= 4)
- SYNC_STAGES, 2, synchroniser flops for vs_udr/vs_uir (>= 2)
- CMD_DEPTH, 4, command FIFO depth (power of 2, >= 2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vs_uir  in  1  update-IR level from TCK domain (asynchronous to clk)
- vs_udr  in  1  update-DR level from TCK domain (asynchronous to clk)
- ir_in  in  IR_W  instruction register; held stable by TCK domain after update-IR
- sr  in  SR_W  data shift register; held stable by TCK domain after update-DR
- jdo  out  SR_W  last captured sr
- take_action  out  NUM_CH  one-cycle pulse, one-hot by latched IR, action bit = 1
- take_no_action  out  NUM_CH  one-cycle pulse, one-hot by latched IR, action bit = 0
- cmd_valid  out  1  FIFO head valid
- cmd_ready  in  1  consumer accepts head
- cmd_ch  out  IR_W  head: channel (latched IR)
- cmd_action  out  1  head: action bit
- cmd_sub  out  2  head: sub-op field
- cmd_data  out  SR_W  head: captured sr
- fifo_count  out  clog2(CMD_DEPTH)+1  occupancy
- overflow  out  1  sticky: a command was dropped
- clr_overflow  in  1  clears overflow

Behaviour:
- Reset: jdo, take_action, take_no_action, cmd_valid, fifo_count, overflow = 0. Latched IR = 0. FIFO emptied; queued commands are discarded, including on reset mid-stream. Synchroniser chains = 0.
- Arming: each strobe path has an arm flag, cleared by reset and set once its synchronised level is seen at 0. A level already high at reset release generates no event.
- Synchronisation: each strobe passes through SYNC_STAGES flops, then a rising-edge detect (one extra flop).
  - An edge on vs_udr at sample cycle 0 yields the internal udr_evt on cycle SYNC_STAGES+1 (cycle 3 at default).
  - uir_evt follows the same timing.
- On uir_evt: latched IR <= ir_in.
- On udr_evt:
  - jdo <= sr.
  - Field decode: action = sr[SR_W-1]; sub = sr[SR_W-2:SR_W-3].
  - Next cycle: exactly one bit of take_action or take_no_action pulses for one cycle, index = latched IR. jdo is valid on the same cycle as the pulse.
  - Push {IR, action, sub, sr} into the FIFO.
- Simultaneous uir_evt and udr_evt: the IR update applies first, so the command uses the new ir_in.
- FIFO:
  - First-word-fall-through; cmd_* valid whenever cmd_valid = 1.
  - Pop when cmd_valid & cmd_ready. A push into an empty FIFO gives cmd_valid = 1 on the following cycle.
  - Full, push, no pop: the command is dropped (pulses still fire) and overflow <= 1; count stays CMD_DEPTH.
  - Full, push and pop in the same cycle: both occur; count is unchanged and there is no overflow.
  - Empty with cmd_ready = 1: no effect.
  - Pointers wrap modulo CMD_DEPTH. Count is computed as push minus pop, with no wrap ambiguity.
- overflow: clr_overflow clears it. A set and a clear in the same cycle resolve as set.
- Back-to-back udr_evt are at least SYNC_STAGES+1 cycles apart by construction. None is lost while the FIFO has space.

Decomposition:
- Package nios_dbg_pkg:
  - field position constants (ACTION_BIT = SR_W-1, SUB_HI, SUB_LO)
  - cmd record type {ch, action, sub, data}
  - clog2 helper
- Sub-module nios_dbg_cmd_fifo: parametrised FWFT FIFO with count, full/empty and drop-on-full.
- Synchroniser and edge detect stay inline, one instance per strobe via a generate loop.

Test Plan (all at defaults: IR_W=2, SR_W=38, SYNC_STAGES=2, CMD_DEPTH=4):
- uir edge with ir_in=2, then udr edge with sr=38'h20_0000_1234 (bit 37 = 1, sub = 00) -> take_action=4'b0100 for one cycle, 4 cycles after udr edge. jdo=38'h20_0000_1234. cmd_valid rises the next cycle with cmd_ch=2, cmd_action=1, cmd_data=38'h20_0000_1234.
- ir_in=1, sr with bit 37 = 0 and bit 36 = 1 -> take_no_action=4'b0010; head cmd_sub=2'b10.
- cmd_ready held 0, 5 udr events -> fifo_count=4, overflow=1 after the 5th. Draining with cmd_ready=1 returns commands 1 to 4 in order; clr_overflow then clears overflow.
- FIFO full, udr_evt coincident with a pop -> fifo_count stays 4 and overflow stays 0; the new command is last in drain order.
- vs_udr held high through reset release -> no pulse and no push. A later low-high cycle -> exactly one command.
- Reset asserted with 3 queued commands -> cmd_valid=0 and fifo_count=0 the next cycle; no stale pulse after release.
